pipe_stall_ctrl: RTL and testbench
==================================

Name: pipe_stall_ctrl

Overview:
- Central pipeline controller for the 5-stage core.
- Generates the per-stage hold vector consumed by the PC and every inter-stage register (if/id, id/ex, ex/mem, mem/wb, wb).
- Sequences pipeline flushes for exceptions, eret and memory-stall timeouts.
- Keeps a saturating stall-cycle performance counter.

Parameters:
- PC_W, 32, width of new_pc, exc_vector and epc_i.
- EXC_VECTOR, 32'h0000_0020, redirect target for exceptions.
- TMO_VECTOR, 32'h0000_0040, redirect target on memory-stall timeout.
- STALL_TIMEOUT, 64, consecutive stallreq_mem cycles that trigger a timeout (legal range 2..65535).
- CNT_W, 32, width of stall_cycles.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- stallreq_id  in  1  load-use hazard from decode.
- stallreq_ex  in  1  multi-cycle op busy in execute.
- stallreq_mem  in  1  data memory not ready.
- exc_req  in  1  exception detected in mem stage.
- eret_req  in  1  eret committing in mem stage.
- epc_i  in  PC_W  return address accompanying eret_req.
- stall  out  6  hold vector: bit0 pc, bit1 if/id, bit2 id/ex, bit3 ex/mem, bit4 mem/wb, bit5 wb.
- flush  out  1  clear all inter-stage registers this cycle.
- new_pc  out  PC_W  redirect target, valid when flush=1.
- timeout_err  out  1  sticky error flag.
- stall_cycles  out  CNT_W  count of cycles with stall!=0.

Behaviour:
- Reset (rst=1 at an edge):
  - state=RUN, flush=0, new_pc=0, timeout_err=0, stall_cycles=0, timeout counter=0.
  - stall is forced to 6'b000000 combinationally while rst=1.
- FSM states: RUN and FLUSH. flush, new_pc and state are registered; stall is combinational from the current state and inputs.
- RUN stall vector, priority mem > ex > id:
  - stallreq_mem → 6'b011111
  - else stallreq_ex → 6'b001111
  - else stallreq_id → 6'b000111
  - else → 6'b000000
  - Zero latency: a request in cycle N holds the pipeline in cycle N.
- FLUSH:
  - Lasts exactly 1 cycle; stall=0, flush=1, new_pc holds the captured target.
  - Next state is RUN unconditionally.
  - All requests, exc_req and eret_req are ignored during FLUSH (they belong to squashed instructions).
- RUN → FLUSH triggers, evaluated at an edge in RUN, priority order:
  1. Timeout: timeout counter == STALL_TIMEOUT-1 while stallreq_mem=1. Captures new_pc=TMO_VECTOR and sets timeout_err=1 (sticky until rst).
  2. exc_req=1 and stallreq_mem=0. Captures new_pc=EXC_VECTOR.
  3. eret_req=1, exc_req=0 and stallreq_mem=0. Captures new_pc=epc_i.
  - exc_req or eret_req while stallreq_mem=1 is not taken; the mem stage re-presents it once unstalled.
  - Latency: trigger sampled at edge N, flush=1 for cycle N+1; stall in cycle N still follows the RUN table.
- On the edge leaving FLUSH: flush→0; new_pc retains its value (don't-care when flush=0).
- Timeout counter:
  - Width ceil(log2(STALL_TIMEOUT)).
  - Increments each RUN cycle with stallreq_mem=1.
  - Clears when stallreq_mem=0, in FLUSH, and on reset.
  - Never wraps: cleared on the timeout transition.
- stall_cycles:
  - +1 on each edge where stall!=0.
  - Saturates at all-ones; no wrap.
- Reset mid-FLUSH or mid-timeout-count: everything returns to reset values next cycle; no pending redirect survives.

Test Plan:
1. rst 2 cycles, then idle → stall=000000, flush=0, stall_cycles=0, timeout_err=0.
2. stallreq_id=1 and stallreq_ex=1 in the same cycle, then stallreq_ex alone 3 cycles → stall=001111 for all 4 cycles; stall_cycles=4.
3. exc_req=1 for 1 cycle with no stalls → next cycle flush=1, new_pc=0x20, stall=0; following cycle flush=0; an exc_req during the FLUSH cycle is ignored.
4. exc_req=1, eret_req=1, epc_i=0x1234 together → new_pc=0x20. Then eret_req alone with epc_i=0x1234 → flush with new_pc=0x1234.
5. exc_req=1 while stallreq_mem=1 for 5 cycles → no flush during the stall, stall=011111. When stallreq_mem drops with exc_req still high → flush next cycle, new_pc=0x20.
6. stallreq_mem held 64 cycles (STALL_TIMEOUT=64) → flush=1 in cycle 65 with new_pc=0x40, timeout_err=1 and sticky. Then rst → timeout_err=0.

Source files
------------

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: per-stage hold vector, flush/redirect sequencing and saturating stall-cycle counter
module pipe_stall_ctrl #(
  parameter int PC_W = 32,
  parameter logic [PC_W-1:0] EXC_VECTOR = 32'h0000_0020,
  parameter logic [PC_W-1:0] TMO_VECTOR = 32'h0000_0040,
  parameter int STALL_TIMEOUT = 64,
  parameter int CNT_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stallreq_id,
  input  logic            stallreq_ex,
  input  logic            stallreq_mem,
  input  logic            exc_req,
  input  logic            eret_req,
  input  logic [PC_W-1:0] epc_i,
  output logic [5:0]      stall,
  output logic            flush,
  output logic [PC_W-1:0] new_pc,
  output logic            timeout_err,
  output logic [CNT_W-1:0] stall_cycles
);
  localparam int TW = $clog2(STALL_TIMEOUT);
  localparam logic [0:0] RUN = 1'b0, FLUSH = 1'b1;
  logic [0:0]      state_q, state_d;
  logic [PC_W-1:0] new_pc_q, new_pc_d;
  logic            err_q, err_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            run, tmo_hit, exc_go, eret_go;
  // exc/eret are deferred while mem stalls; the mem stage re-presents them once it is unstalled
  always_comb begin
    run      = state_q == RUN;
    stall    = (rst || !run) ? 6'b000000 : stallreq_mem ? 6'b011111 : stallreq_ex ? 6'b001111 : stallreq_id ? 6'b000111 : 6'b000000;
    tmo_hit  = run && stallreq_mem && tmo_q == TW'(STALL_TIMEOUT - 1);
    exc_go   = run && exc_req && !stallreq_mem;
    eret_go  = run && eret_req && !exc_req && !stallreq_mem;
    state_d  = (tmo_hit || exc_go || eret_go) ? FLUSH : RUN;
    new_pc_d = tmo_hit ? TMO_VECTOR : exc_go ? EXC_VECTOR : eret_go ? epc_i : new_pc_q;
    tmo_d    = (run && stallreq_mem && !tmo_hit) ? tmo_q + 1'b1 : '0;
    err_d    = err_q | tmo_hit;
    cnt_d    = (stall != 6'b000000 && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      new_pc_q <= '0;
      err_q    <= 1'b0;
      tmo_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      new_pc_q <= new_pc_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
      cnt_q    <= cnt_d;
    end
  end
  assign flush        = state_q == FLUSH;
  assign new_pc       = new_pc_q;
  assign timeout_err  = err_q;
  assign stall_cycles = cnt_q;
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: directed plan plus random traffic, scoreboarded against a cycle-level reference model
module tb_pipe_stall_ctrl;
  localparam int TMO = 64;
  localparam int CW = 8;
  logic clk = 1'b0, rst = 1'b1;
  logic sid = 1'b0, sex = 1'b0, smem = 1'b0, exc = 1'b0, eret = 1'b0;
  logic [31:0] epc = '0;
  logic [5:0] stall;
  logic flush, terr;
  logic [31:0] new_pc;
  logic [CW-1:0] scyc;
  int total = 0, bad = 0, cyc_no = 0;
  typedef struct {
    logic [5:0] st;
    logic fl;
    logic [31:0] pc;
    logic er;
    logic [CW-1:0] cnt;
    int n;
  } exp_t;
  exp_t q[$];
  // reference model state
  bit m_flush = 0, m_err = 0;
  logic [31:0] m_pc = '0;
  int m_cnt = 0, m_run = 0;

  pipe_stall_ctrl #(.STALL_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .stallreq_id(sid), .stallreq_ex(sex), .stallreq_mem(smem),
    .exc_req(exc), .eret_req(eret), .epc_i(epc), .stall(stall), .flush(flush),
    .new_pc(new_pc), .timeout_err(terr), .stall_cycles(scyc));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want, input int n);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cycle=%0d got=0x%0h want=0x%0h", nm, n, got, want);
    end
  endtask

  // one cycle: drive inputs, predict outputs for this cycle, then advance the model across the next edge
  task automatic cyc(input logic r, input logic id, input logic ex, input logic mem,
                     input logic e, input logic er, input logic [31:0] pc);
    exp_t x;
    int held;
    rst = r; sid = id; sex = ex; smem = mem; exc = e; eret = er; epc = pc;
    held = (r || m_flush) ? 0 : mem ? 5 : ex ? 4 : id ? 3 : 0;
    x.st = 6'((1 << held) - 1);
    x.fl = m_flush; x.pc = m_pc; x.er = m_err; x.cnt = CW'(m_cnt); x.n = cyc_no;
    q.push_back(x);
    if (r) begin
      m_flush = 0; m_err = 0; m_pc = '0; m_cnt = 0; m_run = 0;
    end else if (m_flush) begin
      m_flush = 0; m_run = 0;
    end else begin
      if (held != 0 && m_cnt < (1 << CW) - 1) m_cnt++;
      if (mem) begin
        if (m_run + 1 == TMO) begin
          m_flush = 1; m_pc = 32'h40; m_err = 1; m_run = 0;
        end else m_run++;
      end else begin
        m_run = 0;
        if (e) begin m_flush = 1; m_pc = 32'h20; end
        else if (er) begin m_flush = 1; m_pc = pc; end
      end
    end
    @(posedge clk); #1;
    cyc_no++;
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        x = q.pop_front();
        chk("stall", 32'(stall), 32'(x.st), x.n);
        chk("flush", 32'(flush), 32'(x.fl), x.n);
        chk("new_pc", new_pc, x.pc, x.n);
        chk("timeout_err", 32'(terr), 32'(x.er), x.n);
        chk("stall_cycles", 32'(scyc), 32'(x.cnt), x.n);
      end
    end
  end

  initial begin : stim
    int burst = 0;
    logic m;
    @(posedge clk); #1;
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0, 0);
    repeat (3) cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 1, 32'h1234);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 32'h1234);
    cyc(0, 0, 0, 0, 0, 0, 0);
    repeat (5) cyc(0, 0, 0, 1, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    repeat (64) cyc(0, 0, 0, 1, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 1, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    repeat (30) cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 1, 0, 0, 0);
    repeat (66) cyc(0, 0, 1, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4000; i++) begin
      if (burst == 0 && $urandom_range(0, 60) == 0) burst = $urandom_range(1, 80);
      m = burst != 0 ? 1'b1 : ($urandom_range(0, 7) == 0);
      if (burst != 0) burst--;
      cyc($urandom_range(0, 400) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, m,
          $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0, $urandom);
    end
    cyc(0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("drain", 32'(q.size()), 32'd0, cyc_no);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
